// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade input front end.
package arcade_input_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  localparam logic [7:0] IDX_GAME   = 8'd1;
  localparam logic [7:0] IDX_KEYMAP = 8'd253;
  localparam logic [7:0] IDX_DIP    = 8'd254;

  localparam int BIT_RIGHT = 0;
  localparam int BIT_LEFT  = 1;
  localparam int BIT_DOWN  = 2;
  localparam int BIT_UP    = 3;
  localparam int BIT_BTN0  = 4;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/autofire_gen.sv
// Free-running autofire phase generator and per-button gating.
module autofire_gen #(
  parameter int NB  = 12,
  parameter int DIV = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NB-1:0] held,
  input  logic [NB-1:0] mask,
  output logic [NB-1:0] gated
);

  logic [DIV-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + 1'b1;
  end

  assign gated = held & ({NB{cnt[DIV-1]}} | ~mask);

endmodule

// File: rtl/arcade_input_mapper.sv
// Keymap-driven player input mapper with DIP/game-index capture from ioctl.
// Optional per-button autofire is built when AUTOFIRE_EN is defined.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_BUTTONS  = 6,
  parameter int NUM_DIP      = 8,
  parameter int AUTOFIRE_DIV = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [10:0]                                ps2_key,
  input  logic [NUM_PLAYERS*16-1:0]                  joystick,
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0]         autofire_mask,
  input  logic [24:0]                                ioctl_addr,
  input  logic [7:0]                                 ioctl_data,
  input  logic                                       ioctl_wr,
  input  logic [7:0]                                 ioctl_index,
  output logic [NUM_PLAYERS*(BIT_BTN0+NUM_BUTTONS)-1:0] controls,
  output logic [NUM_DIP*8-1:0]                       dip,
  output logic [3:0]                                 game_index,
  output logic                                       busy,
  output logic                                       overflow
);

  localparam int W     = BIT_BTN0 + NUM_BUTTONS;
  localparam int E     = NUM_PLAYERS * W;
  localparam int IDX_W = $clog2(E);
  localparam int DIP_W = (NUM_DIP > 1) ? $clog2(NUM_DIP) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(E - 1);

  // Configuration storage: survives reset, powers up as zero.
  logic [7:0] km_code [E]       = '{default: 8'h00};
  logic       km_ext  [E]       = '{default: 1'b0};
  logic [7:0] dip_mem [NUM_DIP] = '{default: 8'h00};
  logic [3:0] game_r            = 4'd0;

  logic [IDX_W-1:0] km_sel;
  assign km_sel = ioctl_addr[IDX_W:1];

  always_ff @(posedge clk) begin
    if (ioctl_wr && ioctl_index == IDX_KEYMAP && ioctl_addr < 25'(2 * E)) begin
      if (ioctl_addr[0]) km_ext[km_sel]  <= ioctl_data[0];
      else               km_code[km_sel] <= ioctl_data;
    end
    if (ioctl_wr && ioctl_index == IDX_DIP && ioctl_addr < 25'(NUM_DIP))
      dip_mem[ioctl_addr[DIP_W-1:0]] <= ioctl_data;
    if (ioctl_wr && ioctl_index == IDX_GAME)
      game_r <= ioctl_data[3:0];
  end

  // Event detect: the key word is registered once, the toggle bit twice.
  logic [9:0]  key_q;
  logic        tog_d, tog_q;
  logic        event_seen;
  key_event_t  ev;

  always_ff @(posedge clk) begin
    key_q <= ps2_key[9:0];
    tog_d <= ps2_key[10];
    tog_q <= tog_d;
  end

  assign event_seen = (tog_d != tog_q);
  assign ev         = key_event_t'(key_q);

  scan_state_t      state;
  logic [IDX_W-1:0] idx;
  key_event_t       cur, pend;
  logic             pend_vld;
  logic             overflow_r;
  logic [E-1:0]     key_state;
  logic             hit;

  // Entry 0 is reserved as "unmapped" and never matches.
  assign hit = (idx != '0) && ({km_ext[idx], km_code[idx]} == {cur.ext, cur.code});

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pend_vld   <= 1'b0;
      overflow_r <= 1'b0;
      key_state  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx      <= '0;
          pend_vld <= pend_vld & event_seen;
          if (pend_vld || event_seen) state <= ST_SCAN;
        end
        default: begin
          if (hit) key_state[idx] <= cur.pressed;
          idx <= idx + 1'b1;
          if (idx == LAST) state <= ST_IDLE;
          if (event_seen) begin
            if (pend_vld) overflow_r <= 1'b1;
            else          pend_vld   <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE) cur <= pend_vld ? pend : ev;
    if (event_seen && ((state == ST_IDLE) ? pend_vld : !pend_vld)) pend <= ev;
  end

  logic [E-1:0]                       held;
  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_held, btn_out;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign held[p*W +: W] = key_state[p*W +: W] | joystick[16*p +: W];
    assign btn_held[p*NUM_BUTTONS +: NUM_BUTTONS] = held[p*W+BIT_BTN0 +: NUM_BUTTONS];
    assign controls[p*W +: W] = {btn_out[p*NUM_BUTTONS +: NUM_BUTTONS],
                                 held[p*W +: BIT_BTN0]};
  end

`ifdef AUTOFIRE_EN
  autofire_gen #(
    .NB  (NUM_PLAYERS * NUM_BUTTONS),
    .DIV (AUTOFIRE_DIV)
  ) u_autofire (
    .clk   (clk),
    .reset (reset),
    .held  (btn_held),
    .mask  (autofire_mask),
    .gated (btn_out)
  );
`else
  assign btn_out = btn_held;
`endif

  // Joystick bits beyond the control word width (and the mask without autofire) are not used.
  logic unused_inputs;
  assign unused_inputs = ^{joystick, autofire_mask};

  for (genvar n = 0; n < NUM_DIP; n++) begin : g_dip
    assign dip[8*n +: 8] = dip_mem[n];
  end

  assign game_index = game_r;
  assign busy       = (state == ST_SCAN);
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper (2 players, 6 buttons, 8 DIP bytes).
module tb_arcade_input_mapper;
  localparam int NP = 2;
  localparam int NB = 6;
  localparam int ND = 8;
  localparam int W  = 10;
  localparam int E  = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      ps2_key;
  logic [NP*16-1:0] joystick;
  logic [NP*NB-1:0] autofire_mask;
  logic [24:0]      ioctl_addr;
  logic [7:0]       ioctl_data;
  logic             ioctl_wr;
  logic [7:0]       ioctl_index;
  logic [E-1:0]     controls;
  logic [ND*8-1:0]  dip;
  logic [3:0]       game_index;
  logic             busy;
  logic             overflow;

  arcade_input_mapper #(
    .NUM_PLAYERS  (NP),
    .NUM_BUTTONS  (NB),
    .NUM_DIP      (ND),
    .AUTOFIRE_DIV (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_key       (ps2_key),
    .joystick      (joystick),
    .autofire_mask (autofire_mask),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .controls      (controls),
    .dip           (dip),
    .game_index    (game_index),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: keymap contents and logical key states.
  logic [8:0]   km [E];
  logic [E-1:0] ks;

  typedef struct {
    logic [7:0]  index;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [63:0] exp_dip;
    logic [3:0]  exp_game;
  } io_vec_t;
  io_vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic km_write(input int e, input logic ext, input logic [7:0] code);
    ioctl_index = 8'd253;
    ioctl_wr    = 1'b1;
    ioctl_addr  = 25'(2 * e);
    ioctl_data  = code;
    tick();
    ioctl_addr  = 25'(2 * e + 1);
    ioctl_data  = {7'd0, ext};
    tick();
    ioctl_wr    = 1'b0;
    km[e]       = {ext, code};
  endtask

  task automatic key_event(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  // A key event sets every mapped control (entry 0 excluded) to the pressed level.
  task automatic model_event(input logic pressed, input logic ext, input logic [7:0] code);
    for (int e = 1; e < E; e++)
      if (km[e] == {ext, code}) ks[e] = pressed;
  endtask

  function automatic logic [E-1:0] expect_ctrl(input logic [E-1:0] k, input logic [NP*16-1:0] j);
    logic [E-1:0] r;
    for (int p = 0; p < NP; p++)
      for (int b = 0; b < W; b++)
        r[p*W+b] = k[p*W+b] | j[16*p+b];
    return r;
  endfunction

  initial begin
    logic [63:0] last_dip;
    int          nb;
    logic        ext;
    logic        prs;
    logic [7:0]  code;

    vt[0] = '{8'd254, 25'd2, 8'hA5, 64'h0000_0000_00A5_0000, 4'h0};
    vt[1] = '{8'd254, 25'd9, 8'hFF, 64'h0000_0000_00A5_0000, 4'h0};
    vt[2] = '{8'd254, 25'd0, 8'h3C, 64'h0000_0000_00A5_003C, 4'h0};
    vt[3] = '{8'd254, 25'd7, 8'h81, 64'h8100_0000_00A5_003C, 4'h0};
    vt[4] = '{8'd1,   25'd0, 8'h5B, 64'h8100_0000_00A5_003C, 4'hB};
    vt[5] = '{8'd254, 25'd8, 8'h77, 64'h8100_0000_00A5_003C, 4'hB};
    vt[6] = '{8'd2,   25'd0, 8'hEE, 64'h8100_0000_00A5_003C, 4'hB};
    vt[7] = '{8'd1,   25'd5, 8'hF3, 64'h8100_0000_00A5_003C, 4'h3};

    for (int e = 0; e < E; e++) km[e] = '0;
    ks            = '0;
    reset         = 1'b1;
    ps2_key       = '0;
    joystick      = '0;
    autofire_mask = '0;
    ioctl_addr    = '0;
    ioctl_data    = '0;
    ioctl_wr      = 1'b0;
    ioctl_index   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_controls", 64'(controls), 64'd0);
    check("reset_dip", dip, 64'd0);
    check("reset_game", 64'(game_index), 64'd0);

    for (int i = 0; i < 8; i++) begin
      ioctl_index = vt[i].index;
      ioctl_addr  = vt[i].addr;
      ioctl_data  = vt[i].data;
      ioctl_wr    = 1'b1;
      tick();
      ioctl_wr    = 1'b0;
      check($sformatf("io_dip_%0d", i), dip, vt[i].exp_dip);
      check($sformatf("io_game_%0d", i), 64'(game_index), 64'(vt[i].exp_game));
    end
    last_dip = vt[7].exp_dip;

    joystick = 32'h0000_0008;
    tick();
    check("joy_up_p1", 64'(controls[3]), 64'd1);
    joystick = 32'h0215_0123;
    tick();
    check("joy_merge", 64'(controls), 64'(expect_ctrl(ks, joystick)));
    joystick = '0;

    // Press latency: entry 4 updates at event cycle + 6.
    km_write(4, 1'b0, 8'h14);
    key_event(1'b1, 1'b0, 8'h14);
    tick();
    check("scan_busy", 64'(busy), 64'd1);
    repeat (4) tick();
    check("press_early", 64'(controls[4]), 64'd0);
    tick();
    check("press_on_time", 64'(controls[4]), 64'd1);
    model_event(1'b1, 1'b0, 8'h14);
    repeat (20) tick();
    key_event(1'b0, 1'b0, 8'h14);
    repeat (5) tick();
    check("release_early", 64'(controls[4]), 64'd1);
    tick();
    check("release_on_time", 64'(controls[4]), 64'd0);
    model_event(1'b0, 1'b0, 8'h14);
    repeat (20) tick();

    // Shared extended key; a non-extended code must not match.
    km_write(3, 1'b1, 8'h75);
    km_write(13, 1'b1, 8'h75);
    key_event(1'b1, 1'b1, 8'h75);
    model_event(1'b1, 1'b1, 8'h75);
    repeat (22) tick();
    check("ext_both", 64'({controls[13], controls[3]}), 64'd3);
    key_event(1'b0, 1'b0, 8'h75);
    model_event(1'b0, 1'b0, 8'h75);
    repeat (22) tick();
    check("nonext_ignored", 64'(controls), 64'(expect_ctrl(ks, joystick)));
    key_event(1'b0, 1'b1, 8'h75);
    model_event(1'b0, 1'b1, 8'h75);
    repeat (22) tick();
    check("ext_release", 64'(controls), 64'(expect_ctrl(ks, joystick)));

    // Three back-to-back events: two applied, third dropped.
    km_write(5, 1'b0, 8'h21);
    km_write(6, 1'b0, 8'h22);
    km_write(7, 1'b0, 8'h23);
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      key_event(1'b1, 1'b0, 8'(8'h21 + i));
      nb += int'(busy);
    end
    model_event(1'b1, 1'b0, 8'h21);
    model_event(1'b1, 1'b0, 8'h22);
    for (int i = 0; i < 60; i++) begin
      tick();
      nb += int'(busy);
    end
    check("burst_busy_cycles", 64'(nb), 64'd40);
    check("burst_overflow", 64'(overflow), 64'd1);
    check("burst_controls", 64'(controls), 64'(expect_ctrl(ks, joystick)));

    // Reset mid-scan abandons it; configuration storage survives.
    key_event(1'b1, 1'b0, 8'h14);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("midscan_busy", 64'(busy), 64'd0);
    check("midscan_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    ks = '0;
    repeat (25) tick();
    check("post_reset_controls", 64'(controls), 64'd0);
    check("post_reset_dip", dip, last_dip);
    check("post_reset_game", 64'(game_index), 64'h3);

    // Randomised keymap and events against the model.
    for (int e = 1; e < E; e++)
      km_write(e, 1'($urandom_range(0, 1)), 8'(8'h30 + $urandom_range(0, 3)));
    for (int it = 0; it < 40; it++) begin
      joystick = $urandom;
      if (it % 10 == 5)
        km_write($urandom_range(1, E - 1), 1'($urandom_range(0, 1)), 8'(8'h30 + $urandom_range(0, 3)));
      prs  = 1'($urandom_range(0, 1));
      ext  = 1'($urandom_range(0, 1));
      code = 8'(8'h30 + $urandom_range(0, 4));
      key_event(prs, ext, code);
      model_event(prs, ext, code);
      repeat ($urandom_range(22, 28)) tick();
      check($sformatf("rand_%0d", it), 64'(controls), 64'(expect_ctrl(ks, joystick)));
    end
    check("rand_no_overflow", 64'(overflow), 64'd0);

`ifdef AUTOFIRE_EN
    begin
      int   t1, t2, ones;
      logic prev;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ks = '0;
      joystick = 32'h0000_0010;
      autofire_mask = 12'h001;
      t1 = -1;
      t2 = -1;
      tick();
      prev = controls[4];
      for (int i = 0; i < 40; i++) begin
        tick();
        if (controls[4] !== prev) begin
          if (t1 < 0) t1 = i;
          else if (t2 < 0) t2 = i;
        end
        prev = controls[4];
      end
      check("autofire_period", 64'((t1 >= 0 && t2 >= 0) ? (t2 - t1) : -1), 64'd8);
      autofire_mask = '0;
      ones = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        ones += int'(controls[4]);
      end
      check("autofire_masked_off", 64'(ones), 64'd20);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
